// File: rtl/fetch_unit.sv
// Instruction-fetch front end: drives the IMem word PC, registers the returned
// instruction into IF/ID with a valid/ready handshake to decode, and takes
// branch redirects from execute. Optional jump folding via `FETCH_JUMP_FOLD_EN.
module fetch_unit #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [5:0]  JUMP_OPCODE = 6'b000001,
  parameter int          CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [15:0]      imem_pc,
  input  logic [31:0]      imem_instr,
  input  logic             id_ready,
  input  logic             redirect_valid,
  input  logic [15:0]      redirect_pc,
  output logic             if_valid,
  output logic [31:0]      if_instr,
  output logic [15:0]      if_pc,
  output logic [15:0]      if_pc_plus1,
  output logic [CNT_W-1:0] fetch_count
);

`ifdef FETCH_JUMP_FOLD_EN
  localparam bit FoldEn = 1'b1;
`else
  localparam bit FoldEn = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [15:0]      pc_q, pc_d;
  logic             if_valid_q, if_valid_d;
  logic [31:0]      if_instr_q, if_instr_d;
  logic [15:0]      if_pc_q, if_pc_d;
  logic [15:0]      if_pc_plus1_q, if_pc_plus1_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic advance;
  logic transfer;
  logic is_jump;
  logic fold;

  assign advance  = !if_valid_q || id_ready;
  assign transfer = if_valid_q && id_ready;
  assign is_jump  = (imem_instr[31:26] == JUMP_OPCODE);
  assign fold     = FoldEn && is_jump;

  // Next-state: redirect beats stall, advance and fold; BOOT ignores redirects
  // so the reset PC is always fetched first.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    if_valid_d    = if_valid_q;
    if_instr_d    = if_instr_q;
    if_pc_d       = if_pc_q;
    if_pc_plus1_d = if_pc_plus1_q;
    cnt_d         = cnt_q;

    case (state_q)
      S_BOOT: begin
        state_d = S_RUN;
      end
      S_RUN, S_HOLD: begin
        if (redirect_valid) begin
          pc_d       = redirect_pc;
          if_valid_d = 1'b0;
          state_d    = S_RUN;
        end else if (advance) begin
          state_d = S_RUN;
          if (transfer) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          if (fold) begin
            pc_d       = imem_instr[15:0];
            if_valid_d = 1'b0;
          end else begin
            if_instr_d    = imem_instr;
            if_pc_d       = pc_q;
            if_pc_plus1_d = pc_q + 16'd1;
            if_valid_d    = 1'b1;
            pc_d          = pc_q + 16'd1;
          end
        end else begin
          state_d = S_HOLD;
        end
      end
      default: begin
        state_d = S_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_BOOT;
      pc_q          <= RESET_PC;
      if_valid_q    <= 1'b0;
      if_instr_q    <= 32'd0;
      if_pc_q       <= 16'd0;
      if_pc_plus1_q <= 16'd0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      if_valid_q    <= if_valid_d;
      if_instr_q    <= if_instr_d;
      if_pc_q       <= if_pc_d;
      if_pc_plus1_q <= if_pc_plus1_d;
      cnt_q         <= cnt_d;
    end
  end

  assign imem_pc     = pc_q;
  assign if_valid    = if_valid_q;
  assign if_instr    = if_instr_q;
  assign if_pc       = if_pc_q;
  assign if_pc_plus1 = if_pc_plus1_q;
  assign fetch_count = cnt_q;

endmodule
